// File: rtl/ram8_bank.sv
// 8 x WIDTH register bank with post-reset zero-fill sequencer, one-hot word enables and registered read port.
// Latency: read data and rd_valid one cycle after an accepted rd_req; writes are visible to the next cycle's read.
// Backpressure: none; load/rd_req are dropped (not queued) while busy. Optional parity: define RAM8_PARITY_EN.
module ram8_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             rd_req,
`ifdef RAM8_PARITY_EN
    input  logic             inj_perr,
    output logic             perr,
`endif
    output logic [WIDTH-1:0] out,
    output logic             rd_valid,
    output logic             busy
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [2:0]       clr_cnt;
    logic             idle;
    logic             rd_ok;
    logic [DEPTH-1:0] word_en;
    logic [WIDTH-1:0] wr_dat;
    logic [WIDTH-1:0] mem [DEPTH];
`ifdef RAM8_PARITY_EN
    logic             wr_par;
    logic [DEPTH-1:0] par;
`endif

    assign idle  = (state == IDLE);
    assign rd_ok = rst_n & idle & rd_req;
    assign busy  = ~rst_n | ~idle;

    // During CLEAR the counter owns the write port; user loads are ignored.
    always_comb begin
        word_en = '0;
        wr_dat  = '0;
`ifdef RAM8_PARITY_EN
        wr_par  = 1'b0;
`endif
        if (rst_n) begin
            if (!idle) begin
                word_en = ONE_HOT0 << clr_cnt;
            end else if (load) begin
                word_en = ONE_HOT0 << address;
                wr_dat  = in;
`ifdef RAM8_PARITY_EN
                wr_par  = (^in) ^ inj_perr;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (word_en[i]) begin
                mem[i] <= wr_dat;
`ifdef RAM8_PARITY_EN
                par[i] <= wr_par;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 3'd1;
            if (clr_cnt == 3'd7) begin
                state <= IDLE;
            end
        end
    end

    // Read samples pre-edge contents, so a same-address load returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out      <= '0;
            rd_valid <= 1'b0;
`ifdef RAM8_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                out  <= mem[address];
`ifdef RAM8_PARITY_EN
                perr <= par[address] ^ (^mem[address]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_ram8_bank.sv
// Directed table-driven bench for ram8_bank plus hand-written reset/CLEAR corner sequences.
module tb_ram8_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load;
    logic        rd_req;
    logic [15:0] out;
    logic        rd_valid;
    logic        busy;
`ifdef RAM8_PARITY_EN
    logic        inj_perr;
    logic        perr;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        load;
        logic        rd_req;
        logic [2:0]  addr;
        logic [15:0] din;
        logic        exp_vld;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    ram8_bank #(.WIDTH(16), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .address  (address),
        .load     (load),
        .rd_req   (rd_req),
`ifdef RAM8_PARITY_EN
        .inj_perr (inj_perr),
        .perr     (perr),
`endif
        .out      (out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load    = 1'b0;
        rd_req  = 1'b0;
        address = 3'd0;
        in      = 16'h0000;
    endtask

    // Counts edges until busy drops, bounded so a stuck sequencer still reaches the summary.
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        load = 1'b1; rd_req = 1'b0; address = a; in = d;
        tick();
        idle_inputs();
    endtask

    task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string name);
        load = 1'b0; rd_req = 1'b1; address = a;
        tick();
        check({name, "_vld"}, 32'(rd_valid), 32'd1);
        check({name, "_out"}, 32'(out), 32'(exp));
        idle_inputs();
    endtask

    initial begin
        int n;

        for (int k = 0; k < 8; k++)
            vecs.push_back('{1'b0, 1'b1, 3'(k), 16'h0000, 1'b1, 16'h0000});
        for (int k = 0; k < 8; k++)
            vecs.push_back('{1'b1, 1'b0, 3'(k), 16'(16'h1111 * (k + 1)), 1'b0, 16'h0000});
        for (int k = 7; k >= 0; k--)
            vecs.push_back('{1'b0, 1'b1, 3'(k), 16'h0000, 1'b1, 16'(16'h1111 * (k + 1))});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 16'hAAAA, 1'b0, 16'h1111});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 16'h5555, 1'b1, 16'hAAAA});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 16'h0000, 1'b1, 16'h5555});
        vecs.push_back('{1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 16'h5555});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 16'h1234, 1'b0, 16'h5555});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 16'h0000, 1'b1, 16'h1234});

        idle_inputs();
`ifdef RAM8_PARITY_EN
        inj_perr = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_vld", 32'(rd_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        tick();
        rst_n = 1'b1;
        check("busy_at_release", 32'(busy), 32'd1);
        busy_len(n);
        check("init_busy_len", 32'(n), 32'd8);

        foreach (vecs[i]) begin
            load    = vecs[i].load;
            rd_req  = vecs[i].rd_req;
            address = vecs[i].addr;
            in      = vecs[i].din;
            tick();
            check($sformatf("vec%0d_vld", i), 32'(rd_valid), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
        end
        idle_inputs();

        // Requests during CLEAR are dropped; word 1 is already cleared when the cycle-4 load arrives.
        rst_n = 1'b0;
        tick();
        check("rst2_out", 32'(out), 32'd0);
        check("rst2_vld", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        load = 1'b1; address = 3'd5; in = 16'hBEEF;
        tick();
        check("clr3_vld", 32'(rd_valid), 32'd0);
        check("clr3_busy", 32'(busy), 32'd1);
        load = 1'b1; rd_req = 1'b1; address = 3'd1; in = 16'hBEEF;
        tick();
        check("clr4_vld", 32'(rd_valid), 32'd0);
        idle_inputs();
        busy_len(n);
        check("clr_rest_len", 32'(n), 32'd4);
        do_read(3'd5, 16'h0000, "drop_a5");
        do_read(3'd1, 16'h0000, "drop_a1");
        do_read(3'd3, 16'h0000, "drop_a3");

        // Reset during CLEAR must restart the sweep from word 0.
        for (int k = 0; k < 8; k++) do_write(3'(k), 16'hFFFF);
        do_read(3'd2, 16'hFFFF, "fill_a2");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        busy_len(n);
        check("restart_busy_len", 32'(n), 32'd8);
        for (int k = 0; k < 8; k++) do_read(3'(k), 16'h0000, $sformatf("restart_a%0d", k));

`ifdef RAM8_PARITY_EN
        inj_perr = 1'b1;
        do_write(3'd2, 16'h0001);
        inj_perr = 1'b0;
        do_write(3'd4, 16'h0001);
        do_read(3'd2, 16'h0001, "par_a2");
        check("perr_a2", 32'(perr), 32'd1);
        do_read(3'd4, 16'h0001, "par_a4");
        check("perr_a4", 32'(perr), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ram8_bank.md
Name: ram8_bank

Overview:
- 8-word x 16-bit register bank; the storage stage directly downstream of the 8-way load demultiplexer in the RAM hierarchy.
- Consumes a 3-bit address and a load strobe. Internally decodes these into eight one-hot word enables; select 0 enables word 0, and so on up to select 7 for word 7.
- Adds a post-reset clear sequencer, busy indication, and a registered read port with a valid pulse.
- Building block for RAM64 and larger.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of words; fixed at 8, matching the 3-bit address.

Ports:
- clk  input  1  rising-edge clock; all state changes occur only on this edge.
- rst_n  input  1  synchronous, active-low reset.
- in  input  WIDTH  write data.
- address  input  3  word select for both read and write.
- load  input  1  write strobe.
- rd_req  input  1  read request.
- out  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse; out is updated in the same cycle.
- busy  output  1  high while reset is asserted or the clear sequence is running; requests are ignored while high.

Behaviour:
- Reset: a rising clk edge with rst_n=0 forces:
  - state=CLEAR
  - clear counter=0
  - out=0
  - rd_valid=0
  - busy=1
  - Word contents are not touched by the reset itself.
- CLEAR state:
  - Each edge with rst_n=1 writes 0 to word[counter] and increments the counter.
  - Word 7 is written on the 8th edge after reset is released; the state then moves to IDLE and busy goes 0 on that same edge.
  - busy is therefore high for exactly 8 cycles after rst_n rises.
- Reset asserted mid-CLEAR: the sequence restarts at word 0.
- IDLE state, write: load=1 writes in into word[address] at the edge. The write is visible to a read issued on the following cycle.
- IDLE state, read: rd_req=1 latches word[address] into out at the edge and sets rd_valid=1 for exactly one cycle.
  - Latency: 1 cycle from request to data.
  - out holds its value until the next accepted read or reset.
- Back-to-back reads: rd_req held high produces rd_valid=1 on every cycle, with out tracking the address from the previous cycle.
- load and rd_req together at the same address: the read returns the old data (read-before-write), and the write still takes effect.
- load and rd_req together at different addresses: both are performed independently.
- Requests while busy=1: load and rd_req are dropped, not queued. No write occurs and rd_valid stays 0.
- No other states. CLEAR moves only to IDLE; IDLE leaves only on reset.

Optional Feature:
- Macro: RAM8_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write (0 during CLEAR).
  - Adds output perr (1 bit). It is registered alongside out and valid only when rd_valid=1.
  - perr=1 when the stored parity does not match the parity of the data read; reset value 0.
  - Adds a debug input inj_perr (1 bit). When high during a write, it stores inverted parity.
- When undefined: no parity storage, and no perr or inj_perr ports.

Test Plan:
- Hold rst_n=0 for 2 cycles, then release → busy=1 for exactly 8 cycles, then 0. A read of each address 0..7 then returns out=0x0000 with rd_valid=1 one cycle after each request.
- After init, write 0x1111*(k+1) to address k for k=0..7, then read addresses 7 down to 0 → out equals 0x8888, 0x7777, ..., 0x1111 in order. rd_valid is high for 8 consecutive cycles.
- After writing address 3 with 0xAAAA, issue load=1, in=0x5555, rd_req=1, address=3 together → out=0xAAAA. The next read of address 3 returns 0x5555.
- Issue load=1 at address 5 with 0xBEEF during cycle 3 of CLEAR, and rd_req during cycle 4 → no rd_valid pulse. After init, address 5 reads 0x0000.
- Fill all words with 0xFFFF, then pulse rst_n=0 at CLEAR cycle 4 → busy is re-extended to 8 full cycles after release, and all addresses read 0x0000.
- With RAM8_PARITY_EN: write 0x0001 to address 2 with inj_perr=1, and 0x0001 to address 4 with inj_perr=0 → reading address 2 gives perr=1, reading address 4 gives perr=0.
